// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the ALU-control / jump-register decode slice:
// ALUOp values from main control, R-type funct codes and ALU operation codes.
package alu_ctrl_pkg;

    // ALUOp from the main control unit
    localparam logic [1:0] ALUOP_MEM   = 2'b00;
    localparam logic [1:0] ALUOP_BR    = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_RSV   = 2'b11;

    // R-type funct field values
    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;
    // JR is recognised on the low nibble only
    localparam logic [3:0] F_JR  = 4'b1000;

    // ALU operation codes
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_INV = 4'b1111;

    // JR select: low funct nibble matches and ALUOp is MEM or RTYPE (bit 0 clear).
    // An unknown compare falls to the else branch, so X funct bits give 0.
    function automatic logic jr_decode(input logic [1:0] alu_op, input logic [3:0] funct_lo);
        logic jr_s;
        if ((alu_op[0] == 1'b0) && (funct_lo == F_JR)) begin
            jr_s = 1'b1;
        end else begin
            jr_s = 1'b0;
        end
        return jr_s;
    endfunction

endpackage

// File: rtl/alu_jr_dec.sv
// Combinational ALU-control and JR decoder. ALUOp has priority; funct is only
// examined for R-type, so X/Z funct bits never reach alu_ctrl for MEM/BR.
module alu_jr_dec
    import alu_ctrl_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [5:0] funct,
    output logic [3:0] alu_ctrl,
    output logic       jr_ctrl
);

    // Decode ALUOp and, for R-type, the funct field into an ALU operation code
    always_comb begin
        alu_ctrl = ALU_INV;
        case (alu_op)
            ALUOP_MEM:   alu_ctrl = ALU_ADD;
            ALUOP_BR:    alu_ctrl = ALU_SUB;
            ALUOP_RTYPE: begin
                case (funct)
                    F_ADD:   alu_ctrl = ALU_ADD;
                    F_SUB:   alu_ctrl = ALU_SUB;
                    F_AND:   alu_ctrl = ALU_AND;
                    F_OR:    alu_ctrl = ALU_OR;
                    F_SLT:   alu_ctrl = ALU_SLT;
                    default: alu_ctrl = ALU_INV;
                endcase
            end
            ALUOP_RSV:   alu_ctrl = ALU_INV;
            default:     alu_ctrl = ALU_INV;
        endcase
    end

    // Jump-register select from ALUOp bit 0 and the low funct nibble
    always_comb begin
        jr_ctrl = 1'b0;
        jr_ctrl = jr_decode(alu_op, funct[3:0]);
    end

endmodule

// File: rtl/alu_jr_ctrl.sv
// ALU-control / JR decode with combinational outputs for the current stage and
// an ID/EX pipeline register supporting stall (en low) and bubble insert (flush).
module alu_jr_ctrl
    import alu_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] alu_op,
    input  logic [5:0] funct,
    input  logic       en,
    input  logic       flush,
    output logic [3:0] alu_ctrl,
    output logic       jr_ctrl,
    output logic [3:0] alu_ctrl_q,
    output logic       jr_ctrl_q
);

    logic [3:0] alu_ctrl_s;
    logic       jr_ctrl_s;
    logic [3:0] alu_ctrl_r;
    logic       jr_ctrl_r;

    alu_jr_dec u_dec (
        .alu_op   (alu_op),
        .funct    (funct),
        .alu_ctrl (alu_ctrl_s),
        .jr_ctrl  (jr_ctrl_s)
    );

    assign alu_ctrl = alu_ctrl_s;
    assign jr_ctrl  = jr_ctrl_s;

    // ID/EX register: reset and flush clear to a bubble, flush beats en, en low holds
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_ctrl_r <= 4'b0000;
            jr_ctrl_r  <= 1'b0;
        end else if (flush) begin
            alu_ctrl_r <= 4'b0000;
            jr_ctrl_r  <= 1'b0;
        end else if (en) begin
            alu_ctrl_r <= alu_ctrl_s;
            jr_ctrl_r  <= jr_ctrl_s;
        end else begin
            alu_ctrl_r <= alu_ctrl_r;
            jr_ctrl_r  <= jr_ctrl_r;
        end
    end

    assign alu_ctrl_q = alu_ctrl_r;
    assign jr_ctrl_q  = jr_ctrl_r;

endmodule

// File: tb/tb_alu_jr_ctrl.sv
// Directed bench for alu_jr_ctrl: hand-computed expected values checked with
// immediate assertions, combinational outputs and the stall/flush register.
module tb_alu_jr_ctrl;

    logic       clk;
    logic       rst_n;
    logic [1:0] alu_op;
    logic [5:0] funct;
    logic       en;
    logic       flush;
    logic [3:0] alu_ctrl;
    logic       jr_ctrl;
    logic [3:0] alu_ctrl_q;
    logic       jr_ctrl_q;

    int n_cmp;
    int n_fail;

    alu_jr_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .alu_op     (alu_op),
        .funct      (funct),
        .en         (en),
        .flush      (flush),
        .alu_ctrl   (alu_ctrl),
        .jr_ctrl    (jr_ctrl),
        .alu_ctrl_q (alu_ctrl_q),
        .jr_ctrl_q  (jr_ctrl_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Apply decode inputs and check both combinational outputs
    task automatic comb(input string tag, input logic [1:0] op, input logic [5:0] fn,
                        input logic [3:0] exp_alu, input logic exp_jr);
        alu_op = op;
        funct  = fn;
        #1;
        check({tag, "_alu"}, alu_ctrl, exp_alu);
        check({tag, "_jr"}, {3'b000, jr_ctrl}, {3'b000, exp_jr});
    endtask

    // Drive inputs at the falling edge, then sample 1 time unit after the rising edge
    task automatic step(input logic [1:0] op, input logic [5:0] fn, input logic e, input logic f);
        @(negedge clk);
        alu_op = op;
        funct  = fn;
        en     = e;
        flush  = f;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        alu_op = 2'b10;
        funct  = 6'b100000;
        en     = 1'b1;
        flush  = 1'b0;

        // Reset is immediate: checked before any clock edge
        #2;
        check("rst_imm_alu_q", alu_ctrl_q, 4'b0000);
        check("rst_imm_jr_q", {3'b000, jr_ctrl_q}, 4'b0000);
        // Still held across edges with en high
        repeat (2) @(posedge clk);
        #1;
        check("rst_hold_alu_q", alu_ctrl_q, 4'b0000);

        // Release, first edge captures ADD
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("first_cap_alu_q", alu_ctrl_q, 4'b0010);
        check("first_cap_jr_q", {3'b000, jr_ctrl_q}, 4'b0000);

        // Combinational sweeps (register disabled)
        en = 1'b0;
        comb("mem_x",   2'b00, 6'bxxxxxx, 4'b0010, 1'b0);
        comb("br_x",    2'b01, 6'bxxxxxx, 4'b0110, 1'b0);
        comb("rsv",     2'b11, 6'b111111, 4'b1111, 1'b0);
        comb("r_add",   2'b10, 6'b100000, 4'b0010, 1'b0);
        comb("r_sub",   2'b10, 6'b100010, 4'b0110, 1'b0);
        comb("r_and",   2'b10, 6'b100100, 4'b0000, 1'b0);
        comb("r_or",    2'b10, 6'b100101, 4'b0001, 1'b0);
        comb("r_slt",   2'b10, 6'b101010, 4'b0111, 1'b0);
        comb("r_inv",   2'b10, 6'b000111, 4'b1111, 1'b0);
        comb("jr_mem",  2'b00, 6'b001000, 4'b0010, 1'b1);
        comb("jr_rt",   2'b10, 6'b001000, 4'b1111, 1'b1);
        comb("jr_br",   2'b01, 6'b001000, 4'b0110, 1'b0);
        comb("jr_hi",   2'b10, 6'b101000, 4'b1111, 1'b1);
        comb("jr_rsv",  2'b11, 6'b001000, 4'b1111, 1'b0);

        // Held through the sweep since en was low
        check("sweep_hold_alu_q", alu_ctrl_q, 4'b0010);

        // Stall: load ADD, then en low with SUB inputs holds ADD
        step(2'b10, 6'b100000, 1'b1, 1'b0);
        check("load_add_q", alu_ctrl_q, 4'b0010);
        step(2'b10, 6'b100010, 1'b0, 1'b0);
        check("stall1_q", alu_ctrl_q, 4'b0010);
        step(2'b10, 6'b100010, 1'b0, 1'b0);
        check("stall2_q", alu_ctrl_q, 4'b0010);
        step(2'b10, 6'b100010, 1'b1, 1'b0);
        check("load_sub_q", alu_ctrl_q, 4'b0110);

        // Registered JR, then flush with en high clears both
        step(2'b00, 6'b001000, 1'b1, 1'b0);
        check("load_jr_alu_q", alu_ctrl_q, 4'b0010);
        check("load_jr_jr_q", {3'b000, jr_ctrl_q}, 4'b0001);
        step(2'b00, 6'b001000, 1'b1, 1'b1);
        check("flush_alu_q", alu_ctrl_q, 4'b0000);
        check("flush_jr_q", {3'b000, jr_ctrl_q}, 4'b0000);
        // Flush with en low also clears
        step(2'b10, 6'b100101, 1'b1, 1'b0);
        check("load_or_q", alu_ctrl_q, 4'b0001);
        step(2'b10, 6'b100101, 1'b0, 1'b1);
        check("flush_stall_q", alu_ctrl_q, 4'b0000);

        // Mid-operation reset while holding SLT
        step(2'b10, 6'b101010, 1'b1, 1'b0);
        check("load_slt_q", alu_ctrl_q, 4'b0111);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_imm_q", alu_ctrl_q, 4'b0000);
        repeat (2) @(posedge clk);
        #1;
        check("mid_rst_hold_q", alu_ctrl_q, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_cap_q", alu_ctrl_q, 4'b0111);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
